pci_bus_arbiter: RTL



---
 rtl/pci_bus_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin one-hot grants, a turnaround cycle
// between owners, parking on a default master and revocation of unused grants.
//
// state      | meaning
// PARK       | bus parked on PARK_MASTER, arbitrating pending requests
// GRANT      | grant issued, waiting for the master to assert frame
// BUSY       | owner (gnt_id) is running a transaction
// TURNAROUND | one all-zero gnt cycle between owners
module pci_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int PARK_MASTER = 0,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic                           frame,
    input  logic                           irdy,
    output logic [NUM_MASTERS-1:0]         gnt,
    output logic [$clog2(NUM_MASTERS)-1:0] gnt_id,
    output logic                           bus_busy,
    output logic                           timeout_pulse
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(GNT_TIMEOUT + 1);
    localparam logic [IW-1:0]          PARK_ID = IW'(PARK_MASTER);
    localparam logic [CW-1:0]          TC      = CW'(GNT_TIMEOUT - 1);
    localparam logic [NUM_MASTERS-1:0] ONE     = NUM_MASTERS'(1);

    typedef enum logic [1:0] {
        PARK,
        GRANT,
        BUSY,
        TURNAROUND
    } state_t;

    state_t        state;
    logic [IW-1:0] last_owner;
    logic [CW-1:0] cnt;
    logic [IW-1:0] winner;
    logic [IW-1:0] idx;
    logic          win_found;
    logic          bus_idle;

    assign bus_idle = !frame && !irdy;

    // Search starts just after last_owner and wraps, so last_owner is lowest priority.
    always_comb begin
        winner    = '0;
        idx       = '0;
        win_found = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = IW'((int'(last_owner) + i) % NUM_MASTERS);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                winner    = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= PARK;
            gnt           <= ONE << PARK_ID;
            gnt_id        <= PARK_ID;
            last_owner    <= PARK_ID;
            bus_busy      <= 1'b0;
            timeout_pulse <= 1'b0;
            cnt           <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                PARK: begin
                    if (frame) begin
                        state      <= BUSY;
                        bus_busy   <= 1'b1;
                        gnt_id     <= PARK_ID;
                        last_owner <= PARK_ID;
                    end else if (bus_idle && win_found) begin
                        state  <= GRANT;
                        gnt    <= ONE << winner;
                        gnt_id <= winner;
                        cnt    <= '0;
                    end
                end
                GRANT: begin
                    cnt <= cnt + CW'(1);
                    // frame wins over both a withdrawn request and a timeout
                    if (frame) begin
                        state      <= BUSY;
                        bus_busy   <= 1'b1;
                        last_owner <= gnt_id;
                    end else if (!req[gnt_id]) begin
                        state <= TURNAROUND;
                        gnt   <= '0;
                    end else if (cnt == TC) begin
                        state         <= TURNAROUND;
                        gnt           <= '0;
                        timeout_pulse <= 1'b1;
                        last_owner    <= gnt_id;
                    end
                end
                BUSY: begin
                    if (bus_idle) begin
                        state    <= TURNAROUND;
                        bus_busy <= 1'b0;
                        gnt      <= '0;
                    end else if ((req & ~(ONE << gnt_id)) != '0) begin
                        gnt <= '0;
                    end
                end
                TURNAROUND: begin
                    state  <= PARK;
                    gnt    <= ONE << PARK_ID;
                    gnt_id <= PARK_ID;
                end
                default: begin
                    state <= PARK;
                end
            endcase
        end
    end

endmodule
